// File: rtl/rida_pkg.sv
// Shared types and constants for the EX stage: ALU opcodes, forward selects, MUL FSM states.
package rida_pkg;

  localparam int XLEN_DEFAULT   = 32;
  localparam int REG_AW_DEFAULT = 5;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8,
    ALU_MUL = 4'd9
  } alu_op_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/execute_alu.sv
// Combinational ALU for the EX stage with zero flag; MUL is handled by execute_stage.
module execute_alu
  import rida_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [3:0]      i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result,
  output logic            o_zero
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    o_result = '0;
    case (alu_op_e'(i_op))
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_SLT: o_result = {{(XLEN-1){1'b0}}, $signed(i_a) < $signed(i_b)};
      ALU_SLL: o_result = i_a << w_shamt;
      ALU_SRL: o_result = i_a >> w_shamt;
      ALU_SRA: o_result = $unsigned($signed(i_a) >>> w_shamt);
      default: o_result = '0;
    endcase
  end

  assign o_zero = (o_result == '0);

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
// Define EX_MUL_EN to build the iterative shift-add multiplier for ALU op 9.
module execute_stage
  import rida_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int REG_AW = REG_AW_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic [1:0]        ResultSrcE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [3:0]        ALUControlE,
  input  logic [XLEN-1:0]   RD1_E,
  input  logic [XLEN-1:0]   RD2_E,
  input  logic [XLEN-1:0]   Imm_Ext_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [XLEN-1:0]   PCE,
  input  logic [XLEN-1:0]   PCPlus4E,
  input  logic [1:0]        ForwardAE,
  input  logic [1:0]        ForwardBE,
  input  logic [XLEN-1:0]   ResultW,
  output logic              PCSrcE,
  output logic [XLEN-1:0]   PCTargetE,
  output logic              BusyE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic [1:0]        ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [XLEN-1:0]   ALU_ResultM,
  output logic [XLEN-1:0]   WriteDataM,
  output logic [XLEN-1:0]   PCPlus4M
);

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_src_b;
  logic [XLEN-1:0] w_alu_out, w_alu_result, w_write_data;
  logic            w_zero;

  always_comb begin
    case (ForwardAE)
      FWD_WB:  w_fwd_a = ResultW;
      FWD_MEM: w_fwd_a = ALU_ResultM;
      default: w_fwd_a = RD1_E;
    endcase
    case (ForwardBE)
      FWD_WB:  w_fwd_b = ResultW;
      FWD_MEM: w_fwd_b = ALU_ResultM;
      default: w_fwd_b = RD2_E;
    endcase
  end

  assign w_src_b = ALUSrcE ? Imm_Ext_E : w_fwd_b;

  execute_alu #(.XLEN(XLEN)) u_alu (
    .i_op     (ALUControlE),
    .i_a      (w_fwd_a),
    .i_b      (w_src_b),
    .o_result (w_alu_out),
    .o_zero   (w_zero)
  );

  assign PCSrcE    = BranchE & w_zero;
  assign PCTargetE = PCE + Imm_Ext_E;

`ifdef EX_MUL_EN
  localparam int CW = $clog2(XLEN);

  mul_state_e      r_mul_state;
  logic [XLEN-1:0] r_mul_a, r_mul_b, r_mul_acc, r_mul_wd;
  logic [CW-1:0]   r_mul_cnt;
  logic [XLEN-1:0] w_mul_sum;
  logic            w_mul_start;

  assign w_mul_start = (r_mul_state == MUL_IDLE) && (alu_op_e'(ALUControlE) == ALU_MUL);
  assign w_mul_sum   = r_mul_acc + (r_mul_b[0] ? r_mul_a : '0);

  // BUSY accumulates bits 0..XLEN-2; DONE folds in the top bit through w_mul_sum.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mul_state <= MUL_IDLE;
      r_mul_a     <= '0;
      r_mul_b     <= '0;
      r_mul_acc   <= '0;
      r_mul_wd    <= '0;
      r_mul_cnt   <= '0;
    end else begin
      case (r_mul_state)
        MUL_IDLE: if (w_mul_start) begin
          r_mul_a     <= w_fwd_a;
          r_mul_b     <= w_src_b;
          r_mul_wd    <= w_fwd_b;
          r_mul_acc   <= '0;
          r_mul_cnt   <= '0;
          r_mul_state <= MUL_BUSY;
        end
        MUL_BUSY: begin
          r_mul_acc <= w_mul_sum;
          r_mul_a   <= r_mul_a << 1;
          r_mul_b   <= r_mul_b >> 1;
          r_mul_cnt <= r_mul_cnt + CW'(1);
          if (r_mul_cnt == CW'(XLEN-2)) r_mul_state <= MUL_DONE;
        end
        default: r_mul_state <= MUL_IDLE;
      endcase
    end
  end

  // Gated by rst so a held MUL in ID/EX cannot re-assert BusyE while reset is active.
  assign BusyE        = !rst && (w_mul_start || (r_mul_state == MUL_BUSY));
  assign w_alu_result = (r_mul_state == MUL_DONE) ? w_mul_sum : w_alu_out;
  assign w_write_data = (r_mul_state == MUL_DONE) ? r_mul_wd  : w_fwd_b;
`else
  assign BusyE        = 1'b0;
  assign w_alu_result = w_alu_out;
  assign w_write_data = w_fwd_b;
`endif

  // A busy cycle loads an all-zero bubble so the hazard unit never forwards from M.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || BusyE) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= '0;
      RD_M        <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
      PCPlus4M    <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      ALU_ResultM <= w_alu_result;
      WriteDataM  <= w_write_data;
      PCPlus4M    <= PCPlus4E;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: vector table through a scoreboard, then MUL and reset sequences.
module tb_execute_stage;
  import rida_pkg::*;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
`ifdef EX_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              RegWriteE, MemWriteE, BranchE, ALUSrcE;
  logic [1:0]        ResultSrcE, ForwardAE, ForwardBE;
  logic [3:0]        ALUControlE;
  logic [XLEN-1:0]   RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
  logic [REG_AW-1:0] RD_E;
  logic              PCSrcE, BusyE, RegWriteM, MemWriteM;
  logic [XLEN-1:0]   PCTargetE, ALU_ResultM, WriteDataM, PCPlus4M;
  logic [1:0]        ResultSrcM;
  logic [REG_AW-1:0] RD_M;

  execute_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .ResultW(ResultW), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .BusyE(BusyE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  fa, fb;
    logic        src, br;
    logic [31:0] rd1, rd2, resw, imm, pce;
    logic [31:0] res;
    logic        pcsrc;
    logic [31:0] wd;
  } vec_t;

  typedef struct {
    logic        rw, mw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4;
  } exp_m_t;

  exp_m_t sb_q[$];
  vec_t   vecs[17];
  int     n_pass = 0;
  int     n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic [1:0] fa, input logic [1:0] fb,
                              input logic src, input logic br, input logic [31:0] rd1,
                              input logic [31:0] rd2, input logic [31:0] resw, input logic [31:0] imm,
                              input logic [31:0] pce, input logic [31:0] res, input logic pcsrc,
                              input logic [31:0] wd);
    vec_t v;
    v.op = op; v.fa = fa; v.fb = fb; v.src = src; v.br = br; v.rd1 = rd1; v.rd2 = rd2;
    v.resw = resw; v.imm = imm; v.pce = pce; v.res = res; v.pcsrc = pcsrc; v.wd = wd;
    return v;
  endfunction

  task automatic drive_ops(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
    ALUControlE = op; RD1_E = a; RD2_E = b; ForwardAE = 2'b00; ForwardBE = 2'b00;
    ALUSrcE = 1'b0; BranchE = 1'b0; Imm_Ext_E = 32'h0; ResultW = 32'h0;
    RegWriteE = 1'b1; MemWriteE = 1'b0; ResultSrcE = 2'b00; RD_E = rd;
    PCE = 32'h200; PCPlus4E = 32'h204;
  endtask

  task automatic compare_m();
    exp_m_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL sb_empty: got no expected entry, expected one");
    end else begin
      n_pass++;
      e = sb_q.pop_front();
      check("RegWriteM",   {31'h0, RegWriteM}, {31'h0, e.rw});
      check("MemWriteM",   {31'h0, MemWriteM}, {31'h0, e.mw});
      check("ResultSrcM",  {30'h0, ResultSrcM}, {30'h0, e.rs});
      check("RD_M",        {27'h0, RD_M}, {27'h0, e.rd});
      check("ALU_ResultM", ALU_ResultM, e.alu);
      check("WriteDataM",  WriteDataM, e.wd);
      check("PCPlus4M",    PCPlus4M, e.pc4);
    end
  endtask

  task automatic apply_vec(input int idx);
    vec_t   v;
    exp_m_t e;
    logic [31:0] ib;
    v  = vecs[idx];
    ib = idx;
    ALUControlE = v.op; ForwardAE = v.fa; ForwardBE = v.fb; ALUSrcE = v.src; BranchE = v.br;
    RD1_E = v.rd1; RD2_E = v.rd2; ResultW = v.resw; Imm_Ext_E = v.imm; PCE = v.pce;
    PCPlus4E = v.pce + 32'd4;
    RegWriteE = ib[0]; MemWriteE = ib[1]; ResultSrcE = ib[2:1]; RD_E = ib[4:0] + 5'd1;
    e.rw = ib[0]; e.mw = ib[1]; e.rs = ib[2:1]; e.rd = ib[4:0] + 5'd1;
    e.alu = v.res; e.wd = v.wd; e.pc4 = v.pce + 32'd4;
    sb_q.push_back(e);
    #1;
    check($sformatf("PCSrcE[%0d]", idx), {31'h0, PCSrcE}, {31'h0, v.pcsrc});
    check($sformatf("PCTargetE[%0d]", idx), PCTargetE, v.pce + v.imm);
    check($sformatf("BusyE[%0d]", idx), {31'h0, BusyE}, 32'h0);
    @(posedge clk); #1;
    compare_m();
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n_busy;
    bit rw_seen;
    //            op       fa     fb     src   br    rd1           rd2           resw          imm       pce       res           pcsrc wd
    vecs[0]  = mk(ALU_ADD, 2'b00, 2'b00, 1'b0, 1'b0, 32'h8,        32'h8,        32'h0,        32'h0,    32'h0,    32'h10,       1'b0, 32'h8);
    vecs[1]  = mk(ALU_ADD, 2'b10, 2'b00, 1'b0, 1'b0, 32'h99,       32'h5,        32'h0,        32'h0,    32'h4,    32'h15,       1'b0, 32'h5);
    vecs[2]  = mk(ALU_SUB, 2'b00, 2'b01, 1'b0, 1'b0, 32'd10,       32'h77,       32'h3,        32'h0,    32'h8,    32'h7,        1'b0, 32'h3);
    vecs[3]  = mk(ALU_SUB, 2'b00, 2'b11, 1'b0, 1'b0, 32'd10,       32'h4,        32'h55,       32'h0,    32'hC,    32'h6,        1'b0, 32'h4);
    vecs[4]  = mk(ALU_SLT, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFB, 32'h3,        32'h0,        32'h0,    32'h10,   32'h1,        1'b0, 32'h3);
    vecs[5]  = mk(ALU_SRA, 2'b00, 2'b00, 1'b1, 1'b0, 32'h80000000, 32'hAA,       32'h0,        32'h4,    32'h14,   32'hF8000000, 1'b0, 32'hAA);
    vecs[6]  = mk(ALU_SUB, 2'b00, 2'b00, 1'b0, 1'b1, 32'h9,        32'h9,        32'h0,        32'h20,   32'h100,  32'h0,        1'b1, 32'h9);
    vecs[7]  = mk(ALU_SUB, 2'b00, 2'b00, 1'b0, 1'b1, 32'h9,        32'h8,        32'h0,        32'h20,   32'h100,  32'h1,        1'b0, 32'h8);
    vecs[8]  = mk(ALU_AND, 2'b00, 2'b00, 1'b0, 1'b0, 32'hF0F01234, 32'h0FF0FFFF, 32'h0,        32'h0,    32'h18,   32'h00F01234, 1'b0, 32'h0FF0FFFF);
    vecs[9]  = mk(ALU_OR,  2'b00, 2'b00, 1'b0, 1'b0, 32'h00F00000, 32'h0000000F, 32'h0,        32'h0,    32'h1C,   32'h00F0000F, 1'b0, 32'h0000000F);
    vecs[10] = mk(ALU_XOR, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFF0000, 32'h0F0F0F0F, 32'h0,        32'h0,    32'h20,   32'hF0F00F0F, 1'b0, 32'h0F0F0F0F);
    vecs[11] = mk(ALU_SLL, 2'b00, 2'b00, 1'b0, 1'b0, 32'h1,        32'h3F,       32'h0,        32'h0,    32'h24,   32'h80000000, 1'b0, 32'h3F);
    vecs[12] = mk(ALU_SRL, 2'b01, 2'b00, 1'b0, 1'b0, 32'h7,        32'h4,        32'h80000000, 32'h0,    32'h28,   32'h08000000, 1'b0, 32'h4);
    vecs[13] = mk(4'd12,   2'b00, 2'b00, 1'b0, 1'b0, 32'h5,        32'h6,        32'h0,        32'h0,    32'h2C,   32'h0,        1'b0, 32'h6);
    vecs[14] = mk(ALU_ADD, 2'b00, 2'b00, 1'b0, 1'b0, 32'hFFFFFFFF, 32'h2,        32'h0,        32'h0,    32'h30,   32'h1,        1'b0, 32'h2);
    vecs[15] = mk(ALU_ADD, 2'b00, 2'b10, 1'b0, 1'b0, 32'h10,       32'h99,       32'h0,        32'h0,    32'h34,   32'h11,       1'b0, 32'h1);
    vecs[16] = mk(ALU_SUB, 2'b11, 2'b00, 1'b0, 1'b0, 32'h3,        32'h5,        32'h0,        32'h0,    32'h38,   32'hFFFFFFFE, 1'b0, 32'h5);

    // Reset state
    drive_ops(ALU_ADD, 32'h0, 32'h0, 5'd0);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_BusyE", {31'h0, BusyE}, 32'h0);
    check("rst_RegWriteM", {31'h0, RegWriteM}, 32'h0);
    check("rst_ALU_ResultM", ALU_ResultM, 32'h0);
    check("rst_PCPlus4M", PCPlus4M, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 17; i++) apply_vec(i);

    // MUL 7 * 0xFFFFFFFD
    drive_ops(ALU_MUL, 32'h7, 32'hFFFFFFFD, 5'd5);
    if (MUL_EN) begin
      n_busy  = 0;
      rw_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
        #1;
        if (!BusyE) break;
        n_busy++;
        @(posedge clk); #1;
        if (RegWriteM) rw_seen = 1'b1;
        @(negedge clk);
      end
      check("mul_busy_cycles", n_busy, 32'd32);
      check("mul_no_regwrite_while_busy", {31'h0, rw_seen}, 32'h0);
      @(posedge clk); #1;
      check("mul_result", ALU_ResultM, 32'hFFFFFFEB);
      check("mul_RegWriteM", {31'h0, RegWriteM}, 32'h1);
      check("mul_RD_M", {27'h0, RD_M}, 32'd5);
      @(negedge clk);
    end else begin
      #1;
      check("mul_off_BusyE", {31'h0, BusyE}, 32'h0);
      @(posedge clk); #1;
      check("mul_off_result", ALU_ResultM, 32'h0);
      check("mul_off_RegWriteM", {31'h0, RegWriteM}, 32'h1);
      @(negedge clk);
    end

    // Reset in the middle of a MUL, then a plain ADD
    drive_ops(ALU_ADD, 32'h0, 32'h0, 5'd0);
    @(posedge clk); #1;
    @(negedge clk);
    drive_ops(ALU_MUL, 32'h3, 32'h4, 5'd7);
    repeat (10) @(posedge clk);
    #2;
    check("mid_mul_BusyE", {31'h0, BusyE}, {31'h0, MUL_EN});
    rst = 1'b1;
    #1;
    check("mid_rst_BusyE", {31'h0, BusyE}, 32'h0);
    check("mid_rst_RegWriteM", {31'h0, RegWriteM}, 32'h0);
    check("mid_rst_RD_M", {27'h0, RD_M}, 32'h0);
    check("mid_rst_ALU_ResultM", ALU_ResultM, 32'h0);
    check("mid_rst_PCPlus4M", PCPlus4M, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_ops(ALU_ADD, 32'h1, 32'h1, 5'd3);
    #1;
    check("post_rst_BusyE", {31'h0, BusyE}, 32'h0);
    @(posedge clk); #1;
    check("post_rst_add", ALU_ResultM, 32'h2);
    check("post_rst_RD_M", {27'h0, RD_M}, 32'd3);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
